// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdop encodings (4 bits; 4'h0 is "no MD operation")
//   - FSM state encoding
//   - is_md_start(): ops that launch a multi-cycle operation
//   - is_div_op():   ops that use the divide latency
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU/MSUB/MSUBU as start ops).
package mdu_pkg;

  localparam logic [3:0] MDOP_NONE  = 4'h0;
  localparam logic [3:0] MDOP_MULT  = 4'h1;
  localparam logic [3:0] MDOP_MULTU = 4'h2;
  localparam logic [3:0] MDOP_DIV   = 4'h3;
  localparam logic [3:0] MDOP_DIVU  = 4'h4;
  localparam logic [3:0] MDOP_MFHI  = 4'h5;
  localparam logic [3:0] MDOP_MFLO  = 4'h6;
  localparam logic [3:0] MDOP_MTHI  = 4'h7;
  localparam logic [3:0] MDOP_MTLO  = 4'h8;
  localparam logic [3:0] MDOP_MADD  = 4'h9;
  localparam logic [3:0] MDOP_MADDU = 4'hA;
  localparam logic [3:0] MDOP_MSUB  = 4'hB;
  localparam logic [3:0] MDOP_MSUBU = 4'hC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_md_start(input logic [3:0] op);
    case (op)
      MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDOP_MADD, MDOP_MADDU, MDOP_MSUB, MDOP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath of the multiply/divide unit.
// Produces the {hi,lo} value that an operation will commit.
//   mdop   in  4   operation code
//   rs,rt  in  32  operands
//   hi,lo  in  32  current architectural HI/LO (accumulate base, divide-by-zero hold)
//   res_hi out 32  result for HI
//   res_lo out 32  result for LO
// Optional feature macro: MDU_MADD_EN (multiply-accumulate/subtract paths).
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  mdop,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic        mul_signed;
  logic        div_signed;
  logic [63:0] a64, b64, prod;
  logic [31:0] abs_a, abs_b, divisor;
  logic [31:0] q_mag, r_mag, quot, rem;

  always_comb begin
    mul_signed = (mdop == MDOP_MULT) || (mdop == MDOP_MADD) || (mdop == MDOP_MSUB);
    div_signed = (mdop == MDOP_DIV);

    // 64x64 with 64-bit result: low 64 bits are the exact two's-complement product.
    a64  = mul_signed ? {{32{rs[31]}}, rs} : {32'b0, rs};
    b64  = mul_signed ? {{32{rt[31]}}, rt} : {32'b0, rt};
    prod = a64 * b64;

    // Signed divide via magnitudes; -0x80000000 wraps to 0x80000000 which is
    // the correct magnitude, so the min/-1 case needs no special handling.
    abs_a   = (div_signed && rs[31]) ? -rs : rs;
    abs_b   = (div_signed && rt[31]) ? -rt : rt;
    divisor = (rt == 32'b0) ? 32'd1 : abs_b;
    q_mag   = abs_a / divisor;
    r_mag   = abs_a % divisor;
    quot    = (div_signed && (rs[31] ^ rt[31])) ? -q_mag : q_mag;
    rem     = (div_signed && rs[31]) ? -r_mag : r_mag;

    {res_hi, res_lo} = {hi, lo};
    case (mdop)
      MDOP_MULT, MDOP_MULTU: {res_hi, res_lo} = prod;
      MDOP_DIV, MDOP_DIVU: begin
        // Divide by zero leaves HI/LO as they were.
        if (rt != 32'b0) {res_hi, res_lo} = {rem, quot};
      end
`ifdef MDU_MADD_EN
      MDOP_MADD, MDOP_MADDU: {res_hi, res_lo} = {hi, lo} + prod;
      MDOP_MSUB, MDOP_MSUBU: {res_hi, res_lo} = {hi, lo} - prod;
`endif
      default: {res_hi, res_lo} = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit with HI/LO ownership.
//   clk            in  1   rising-edge clock
//   reset          in  1   asynchronous, active-low
//   md_valid       in  1   E-stage MD-class instruction present
//   mdop           in  4   operation code (mdu_pkg)
//   rs_val,rt_val  in  32  operands
//   busy           out 1   multi-cycle operation in flight
//   busy_or_start  out 1   busy, or a start op is being presented
//   md_rdata       out 32  HI on MFHI, LO on MFLO, else 0
//   hi, lo         out 32  architectural HI/LO
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops).
//
// state   | meaning
// IDLE    | no operation in flight; accepts start and MTHI/MTLO
// RUN     | counting down; result held in hi_pend/lo_pend until cnt==0
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [3:0]  mdop,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        busy_or_start,
  output logic [31:0] md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic [31:0]      arith_hi, arith_lo;
  logic             start;

  mdu_arith u_arith (
    .mdop   (mdop),
    .rs     (rs_val),
    .rt     (rt_val),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (arith_hi),
    .res_lo (arith_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
    end
  end

  always_comb begin
    start     = md_valid && (state_q == ST_IDLE) && is_md_start(mdop);
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Result is computed from operands and HI/LO at start, then held.
          hi_pend_d = arith_hi;
          lo_pend_d = arith_lo;
          cnt_d     = is_div_op(mdop) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          state_d   = ST_RUN;
        end else if (md_valid && (mdop == MDOP_MTHI)) begin
          hi_d = rs_val;
        end else if (md_valid && (mdop == MDOP_MTLO)) begin
          lo_d = rs_val;
        end
      end
      ST_RUN: begin
        // Requests arriving while busy are dropped here by construction.
        if (cnt_q == '0) begin
          hi_d    = hi_pend_q;
          lo_d    = lo_pend_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (mdop)
      MDOP_MFHI: md_rdata = hi_q;
      MDOP_MFLO: md_rdata = lo_q;
      default:   md_rdata = 32'b0;
    endcase
  end

  assign busy          = (state_q == ST_RUN);
  assign busy_or_start = busy || (md_valid && is_md_start(mdop));
  assign hi            = hi_q;
  assign lo            = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_valid;
  logic [3:0]  mdop;
  logic [31:0] rs_val, rt_val;
  logic        busy, busy_or_start;
  logic [31:0] md_rdata, hi, lo;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk           (clk),
    .reset         (reset),
    .md_valid      (md_valid),
    .mdop          (mdop),
    .rs_val        (rs_val),
    .rt_val        (rt_val),
    .busy          (busy),
    .busy_or_start (busy_or_start),
    .md_rdata      (md_rdata),
    .hi            (hi),
    .lo            (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model built on 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MDOP_MULT:  return 64'(sa * sb);
      MDOP_MULTU: return ua * ub;
      MDOP_DIV: begin
        if (b == 32'b0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MDOP_DIVU: begin
        if (b == 32'b0) return {h, l};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {h, l};
    endcase
  endfunction

  task automatic drive_idle();
    md_valid = 1'b0;
    mdop     = MDOP_NONE;
    rs_val   = 32'b0;
    rt_val   = 32'b0;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    md_valid = 1'b1; mdop = MDOP_MTHI; rs_val = h;
    @(negedge clk);
    mdop = MDOP_MTLO; rs_val = l;
    @(negedge clk);
    drive_idle();
    m_hi = h;
    m_lo = l;
  endtask

  // Presents a start op for one cycle; expected result goes to the scoreboard.
  task automatic start_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] expv);
    exp_q.push_back(expv);
    @(negedge clk);
    md_valid = 1'b1; mdop = op; rs_val = a; rt_val = b;
    #1;
    checks++;
    if (busy_or_start !== 1'b1)
      $display("FAIL %s busy_or_start at start: got %b expected 1", name, busy_or_start);
    if (busy_or_start !== 1'b1) errors++;
    @(negedge clk);
    drive_idle();
  endtask

  // Called at the first busy negedge; counts busy cycles and checks the commit.
  task automatic wait_commit(input string name, input int n_exp, input bit chk_bos);
    int          n;
    int          bos_bad;
    logic [63:0] expv;
    n = 0;
    bos_bad = 0;
    checks++;
    if ({hi, lo} !== {m_hi, m_lo}) begin
      errors++;
      $display("FAIL %s hilo early: got %h expected %h", name, {hi, lo}, {m_hi, m_lo});
    end
    while (busy === 1'b1 && n < 40) begin
      if (chk_bos && busy_or_start !== 1'b1) bos_bad++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != n_exp) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, n, n_exp);
    end
    if (chk_bos) begin
      checks++;
      if (bos_bad != 0) begin
        errors++;
        $display("FAIL %s busy_or_start low while busy: got %0d cycles expected 0", name, bos_bad);
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty at commit", name);
    end else begin
      expv = exp_q.pop_front();
      if ({hi, lo} !== expv) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", name, {hi, lo}, expv);
      end
      m_hi = expv[63:32];
      m_lo = expv[31:0];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    mdop = MDOP_MFHI;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || busy_or_start !== 1'b0) begin
      errors++;
      $display("FAIL reset busy: got %b/%b expected 0/0", busy, busy_or_start);
    end
    checks++;
    if (hi !== 32'b0 || lo !== 32'b0 || md_rdata !== 32'b0) begin
      errors++;
      $display("FAIL reset regs: got hi=%h lo=%h rd=%h expected 0", hi, lo, md_rdata);
    end
    m_hi = 32'b0;
    m_lo = 32'b0;
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    start_op("mult", MDOP_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    wait_commit("mult", MULT_N, 1'b0);
    start_op("multu", MDOP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA);
    wait_commit("multu", MULT_N, 1'b0);
  endtask

  task automatic test_div();
    start_op("div", MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_commit("div", DIV_N, 1'b0);
    start_op("divu_zero", MDOP_DIVU, 32'd7, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_commit("divu_zero", DIV_N, 1'b0);
    start_op("div_min", MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    wait_commit("div_min", DIV_N, 1'b0);
  endtask

  task automatic test_mt_mf();
    @(negedge clk);
    md_valid = 1'b1; mdop = MDOP_MTLO; rs_val = 32'h0000_1234;
    @(negedge clk);
    mdop = MDOP_MFLO; rs_val = 32'b0;
    #1;
    checks++;
    if (md_rdata !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mflo: got %h expected 00001234", md_rdata);
    end
    @(negedge clk);
    mdop = MDOP_MTHI; rs_val = 32'h0000_ABCD;
    @(negedge clk);
    mdop = MDOP_MFHI; rs_val = 32'b0;
    #1;
    checks++;
    if (md_rdata !== 32'h0000_ABCD) begin
      errors++;
      $display("FAIL mfhi: got %h expected 0000abcd", md_rdata);
    end
    drive_idle();
    m_hi = 32'h0000_ABCD;
    m_lo = 32'h0000_1234;
    // MTHI held for the whole busy window must be dropped.
    start_op("mthi_busy", MDOP_MULT, 32'd2, 32'd3, 64'h0000_0000_0000_0006);
    md_valid = 1'b1; mdop = MDOP_MTHI; rs_val = 32'h0000_DEAD;
    @(negedge clk);
    checks++;
    if (hi !== 32'h0000_ABCD) begin
      errors++;
      $display("FAIL mthi_busy hi: got %h expected 0000abcd", hi);
    end
    wait_commit("mthi_busy", MULT_N - 1, 1'b0);
    drive_idle();
  endtask

  task automatic test_back_to_back();
    start_op("b2b", MDOP_MULT, 32'd5, 32'd7, 64'd35);
    md_valid = 1'b1; mdop = MDOP_MULT; rs_val = 32'd100; rt_val = 32'd100;
    wait_commit("b2b", MULT_N, 1'b1);
    drive_idle();
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== 64'd35) begin
      errors++;
      $display("FAIL b2b late: got busy=%b hilo=%h expected 0/%h", busy, {hi, lo}, 64'd35);
    end
  endtask

  task automatic test_reset_mid_run();
    set_hilo(32'h11, 32'h22);
    start_op("rst_div", MDOP_DIV, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'b0 || lo !== 32'b0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    exp_q.delete();
    m_hi = 32'b0;
    m_lo = 32'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'b0 || lo !== 32'b0) begin
      errors++;
      $display("FAIL rst_late: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_madd();
    set_hilo(32'd0, 32'd5);
`ifdef MDU_MADD_EN
    start_op("madd", MDOP_MADD, 32'd2, 32'd3, 64'd11);
    wait_commit("madd", MULT_N, 1'b0);
    start_op("msubu", MDOP_MSUBU, 32'd1, 32'd20, 64'hFFFF_FFFF_FFFF_FFF7);
    wait_commit("msubu", MULT_N, 1'b0);
`else
    @(negedge clk);
    md_valid = 1'b1; mdop = MDOP_MADD; rs_val = 32'd2; rt_val = 32'd3;
    #1;
    checks++;
    if (busy_or_start !== 1'b0) begin
      errors++;
      $display("FAIL madd_off bos: got %b expected 0", busy_or_start);
    end
    @(negedge clk);
    drive_idle();
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== 64'd5) begin
      errors++;
      $display("FAIL madd_off state: got busy=%b hilo=%h expected 0/%h", busy, {hi, lo}, 64'd5);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: op = MDOP_MULT;
        1: op = MDOP_MULTU;
        2: op = MDOP_DIV;
        default: op = MDOP_DIVU;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      start_op("rand", op, a, b, model(op, a, b, m_hi, m_lo));
      wait_commit("rand", is_div_op(op) ? DIV_N : MULT_N, 1'b0);
    end
  endtask

  initial begin
    drive_idle();
    reset = 1'b0;
    m_hi = 32'b0;
    m_lo = 32'b0;
    test_reset();
    test_mult();
    test_div();
    test_mt_mf();
    test_back_to_back();
    test_reset_mid_run();
    test_madd();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
